usb_desc_reader: RTL and testbench

Control-endpoint GET_DESCRIPTOR responder sitting directly downstream of `usb_desc`. It decodes a latched setup request, selects the descriptor's ROM address and length from `usb_desc`, and drives `i_descrom_raddr`. It streams ROM bytes into the EP0 IN transmit path as max-packet-sized data packets, with retry, zero-length-packet and stall handling.

---
 rtl/usb_desc_pkg.sv | 33 +++
 rtl/usb_desc_lookup.sv | 90 +++++++++
 rtl/usb_desc_reader.sv | 222 ++++++++++++++++++++++
 tb/tb_usb_desc_reader.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_desc_pkg.sv
// rtl/usb_desc_pkg.sv - shared constants and state encoding for the EP0 descriptor reader
package usb_desc_pkg;

  // bDescriptorType values handled by the reader
  localparam logic [7:0] DT_DEV   = 8'd1;
  localparam logic [7:0] DT_CFG   = 8'd2;
  localparam logic [7:0] DT_STR   = 8'd3;
  localparam logic [7:0] DT_QUAL  = 8'd6;
  localparam logic [7:0] DT_OSCFG = 8'd7;

  // String descriptor indices
  localparam logic [1:0] STR_LANG    = 2'd0;
  localparam logic [1:0] STR_VENDOR  = 2'd1;
  localparam logic [1:0] STR_PRODUCT = 2'd2;
  localparam logic [1:0] STR_SERIAL  = 2'd3;

  // Fixed descriptor lengths
  localparam logic [7:0] DEV_LEN  = 8'd18;
  localparam logic [7:0] QUAL_LEN = 8'd10;
  localparam logic [7:0] LANG_LEN = 8'd4;

  // Other-speed configuration reuses a configuration image with its type byte patched
  localparam logic [7:0] OSCFG_TYPE_BYTE = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WAIT_IN,
    ST_SEND,
    ST_WAIT_ACK
  } state_t;

endpackage

// File: rtl/usb_desc_lookup.sv
// rtl/usb_desc_lookup.sv - maps descriptor type/index/speed to ROM base, length and stall
module usb_desc_lookup
  import usb_desc_pkg::*;
#(
  parameter int HSSUPPORT = 1
) (
  input  logic [7:0] desc_type,
  input  logic [7:0] desc_index,
  input  logic       highspeed,
  input  logic       have_strings,
  input  logic [9:0] dev_addr,
  input  logic [9:0] qual_addr,
  input  logic [9:0] fscfg_addr,
  input  logic [7:0] fscfg_len,
  input  logic [9:0] hscfg_addr,
  input  logic [7:0] hscfg_len,
  input  logic [9:0] strlang_addr,
  input  logic [9:0] strvendor_addr,
  input  logic [7:0] strvendor_len,
  input  logic [9:0] strproduct_addr,
  input  logic [7:0] strproduct_len,
  input  logic [9:0] strserial_addr,
  input  logic [7:0] strserial_len,
  output logic [9:0] base,
  output logic [7:0] len,
  output logic       subst,
  output logic       stall
);

  // Descriptor selection; anything not recognised stalls the control transfer
  always_comb begin
    base  = 10'd0;
    len   = 8'd0;
    subst = 1'b0;
    stall = 1'b0;
    case (desc_type)
      DT_DEV: begin
        base = dev_addr;
        len  = DEV_LEN;
      end
      DT_CFG: begin
        base = highspeed ? hscfg_addr : fscfg_addr;
        len  = highspeed ? hscfg_len : fscfg_len;
      end
      DT_QUAL: begin
        if (HSSUPPORT == 0) begin
          stall = 1'b1;
        end else begin
          base = qual_addr;
          len  = QUAL_LEN;
        end
      end
      DT_OSCFG: begin
        if (HSSUPPORT == 0) begin
          stall = 1'b1;
        end else begin
          base  = highspeed ? fscfg_addr : hscfg_addr;
          len   = highspeed ? fscfg_len : hscfg_len;
          subst = 1'b1;
        end
      end
      DT_STR: begin
        if (!have_strings || desc_index > 8'd3) begin
          stall = 1'b1;
        end else begin
          case (desc_index[1:0])
            STR_LANG: begin
              base = strlang_addr;
              len  = LANG_LEN;
            end
            STR_VENDOR: begin
              base = strvendor_addr;
              len  = strvendor_len;
            end
            STR_PRODUCT: begin
              base = strproduct_addr;
              len  = strproduct_len;
            end
            default: begin
              base = strserial_addr;
              len  = strserial_len;
            end
          endcase
        end
      end
      default: stall = 1'b1;
    endcase
  end

endmodule

// File: rtl/usb_desc_reader.sv
// rtl/usb_desc_reader.sv - EP0 GET_DESCRIPTOR responder streaming ROM bytes as IN packets
module usb_desc_reader
  import usb_desc_pkg::*;
#(
  parameter int EP0_MAXPKT = 64,
  parameter int HSSUPPORT  = 1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        i_req_valid,
  input  logic [7:0]  i_desc_type,
  input  logic [7:0]  i_desc_index,
  input  logic [15:0] i_wlength,
  input  logic        i_highspeed,
  input  logic [9:0]  i_desc_dev_addr,
  input  logic [9:0]  i_desc_qual_addr,
  input  logic [9:0]  i_desc_fscfg_addr,
  input  logic [7:0]  i_desc_fscfg_len,
  input  logic [9:0]  i_desc_hscfg_addr,
  input  logic [7:0]  i_desc_hscfg_len,
  input  logic [9:0]  i_desc_strlang_addr,
  input  logic [9:0]  i_desc_strvendor_addr,
  input  logic [7:0]  i_desc_strvendor_len,
  input  logic [9:0]  i_desc_strproduct_addr,
  input  logic [7:0]  i_desc_strproduct_len,
  input  logic [9:0]  i_desc_strserial_addr,
  input  logic [7:0]  i_desc_strserial_len,
  input  logic        i_descrom_have_strings,
  output logic [9:0]  o_descrom_raddr,
  input  logic [7:0]  i_descrom_rdat,
  input  logic        i_in_token,
  input  logic        i_ack,
  input  logic        i_nak_retry,
  output logic [7:0]  o_txdat,
  output logic        o_txvalid,
  input  logic        i_txready,
  output logic        o_txlast,
  output logic        o_zlp,
  output logic        o_stall,
  output logic        o_busy
);

  localparam logic [7:0] MAXPKT8 = 8'(EP0_MAXPKT);
  localparam logic [7:0] MASK8   = 8'(EP0_MAXPKT - 1);

  state_t      state_q, state_d;
  logic [7:0]  type_q, index_q;
  logic [15:0] wlen_q;
  logic        hs_q;
  logic [9:0]  base_q, base_d;
  logic [7:0]  total_q, total_d;
  logic [7:0]  sent_q, sent_d;
  logic [7:0]  pkt_off_q, pkt_off_d;
  logic        need_zlp_q, need_zlp_d;
  logic        zlp_pend_q, zlp_pend_d;
  logic        subst_q, subst_d;
  logic        stall_q, stall_d;
  logic        zlp_q, zlp_d;
  logic [9:0]  raddr_q, raddr_d;

  logic [9:0]  lk_base;
  logic [7:0]  lk_len;
  logic        lk_subst, lk_stall;
  logic [7:0]  lk_total;
  logic [7:0]  remain, pkt_len, cur_off;
  logic        last_byte;

  usb_desc_lookup #(.HSSUPPORT(HSSUPPORT)) u_lookup (
    .desc_type       (type_q),
    .desc_index      (index_q),
    .highspeed       (hs_q),
    .have_strings    (i_descrom_have_strings),
    .dev_addr        (i_desc_dev_addr),
    .qual_addr       (i_desc_qual_addr),
    .fscfg_addr      (i_desc_fscfg_addr),
    .fscfg_len       (i_desc_fscfg_len),
    .hscfg_addr      (i_desc_hscfg_addr),
    .hscfg_len       (i_desc_hscfg_len),
    .strlang_addr    (i_desc_strlang_addr),
    .strvendor_addr  (i_desc_strvendor_addr),
    .strvendor_len   (i_desc_strvendor_len),
    .strproduct_addr (i_desc_strproduct_addr),
    .strproduct_len  (i_desc_strproduct_len),
    .strserial_addr  (i_desc_strserial_addr),
    .strserial_len   (i_desc_strserial_len),
    .base            (lk_base),
    .len             (lk_len),
    .subst           (lk_subst),
    .stall           (lk_stall)
  );

  // Transfer length is clipped to what the host asked for
  assign lk_total  = (wlen_q < {8'h00, lk_len}) ? wlen_q[7:0] : lk_len;
  assign remain    = total_q - sent_q;
  assign pkt_len   = (remain > MAXPKT8) ? MAXPKT8 : remain;
  assign cur_off   = sent_q + pkt_off_q;
  assign last_byte = (pkt_off_q == pkt_len - 8'd1);

  assign o_descrom_raddr = raddr_q;
  assign o_txvalid       = (state_q == ST_SEND);
  assign o_txlast        = o_txvalid && last_byte;
  assign o_txdat         = (subst_q && cur_off == 8'd1) ? OSCFG_TYPE_BYTE : i_descrom_rdat;
  assign o_zlp           = zlp_q;
  assign o_stall         = stall_q;
  assign o_busy          = (state_q != ST_IDLE);

  // Next-state, counters and one-cycle ZLP strobe
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    total_d    = total_q;
    sent_d     = sent_q;
    pkt_off_d  = pkt_off_q;
    need_zlp_d = need_zlp_q;
    zlp_pend_d = zlp_pend_q;
    subst_d    = subst_q;
    stall_d    = stall_q;
    zlp_d      = 1'b0;
    if (i_req_valid) begin
      state_d    = ST_LOOKUP;
      stall_d    = 1'b0;
      sent_d     = 8'd0;
      pkt_off_d  = 8'd0;
      zlp_pend_d = 1'b0;
    end else begin
      case (state_q)
        ST_LOOKUP: begin
          if (lk_stall) begin
            stall_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            base_d     = lk_base;
            subst_d    = lk_subst;
            total_d    = lk_total;
            need_zlp_d = ((lk_total & MASK8) == 8'd0) && ({8'h00, lk_total} < wlen_q);
            zlp_pend_d = (lk_total == 8'd0);
            state_d    = ST_WAIT_IN;
          end
        end
        ST_WAIT_IN: begin
          if (i_in_token) begin
            if (zlp_pend_q) begin
              zlp_d      = 1'b1;
              zlp_pend_d = 1'b0;
              state_d    = ST_IDLE;
            end else begin
              state_d = ST_SEND;
            end
          end
        end
        ST_SEND: begin
          if (i_txready) begin
            if (last_byte) begin
              state_d = ST_WAIT_ACK;
            end else begin
              pkt_off_d = pkt_off_q + 8'd1;
            end
          end
        end
        ST_WAIT_ACK: begin
          if (i_nak_retry) begin
            pkt_off_d = 8'd0;
            state_d   = ST_WAIT_IN;
          end else if (i_ack) begin
            sent_d    = sent_q + pkt_len;
            pkt_off_d = 8'd0;
            if (sent_d < total_q) begin
              state_d = ST_WAIT_IN;
            end else if (need_zlp_q) begin
              zlp_pend_d = 1'b1;
              state_d    = ST_WAIT_IN;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    raddr_d = base_d + {2'b00, sent_d} + {2'b00, pkt_off_d};
  end

  // State, counters, latched request and registered ROM address
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      type_q     <= 8'd0;
      index_q    <= 8'd0;
      wlen_q     <= 16'd0;
      hs_q       <= 1'b0;
      base_q     <= 10'd0;
      total_q    <= 8'd0;
      sent_q     <= 8'd0;
      pkt_off_q  <= 8'd0;
      need_zlp_q <= 1'b0;
      zlp_pend_q <= 1'b0;
      subst_q    <= 1'b0;
      stall_q    <= 1'b0;
      zlp_q      <= 1'b0;
      raddr_q    <= 10'd0;
    end else begin
      if (i_req_valid) begin
        type_q  <= i_desc_type;
        index_q <= i_desc_index;
        wlen_q  <= i_wlength;
        hs_q    <= i_highspeed;
      end
      state_q    <= state_d;
      base_q     <= base_d;
      total_q    <= total_d;
      sent_q     <= sent_d;
      pkt_off_q  <= pkt_off_d;
      need_zlp_q <= need_zlp_d;
      zlp_pend_q <= zlp_pend_d;
      subst_q    <= subst_d;
      stall_q    <= stall_d;
      zlp_q      <= zlp_d;
      raddr_q    <= raddr_d;
    end
  end

endmodule

// File: tb/tb_usb_desc_reader.sv
// tb/tb_usb_desc_reader.sv - randomized self-checking bench for usb_desc_reader
module tb_usb_desc_reader;

  localparam int A_DEV = 10'h000, A_QUAL = 10'h020, A_FS = 10'h040, A_HS = 10'h080;
  localparam int A_LANG = 10'h100, A_VEN = 10'h110, A_PRO = 10'h130, A_SER = 10'h170;
  localparam int L_FS = 41, L_HS = 32, L_VEN = 20, L_PRO = 48, L_SER = 0;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  logic        req_valid = 1'b0, highspeed = 1'b0, have_strings = 1'b1;
  logic [7:0]  desc_type = 8'd0, desc_index = 8'd0;
  logic [15:0] wlength = 16'd0;
  logic        in_token = 1'b0, ack = 1'b0, nak = 1'b0, txready = 1'b0;
  logic [7:0]  rom [0:1023];

  logic [1:0][9:0] raddr;
  logic [1:0][7:0] rdat, txdat;
  logic [1:0]      txvalid, txlast, zlp, stall, busy;

  assign rdat[0] = rom[raddr[0]];
  assign rdat[1] = rom[raddr[1]];

  usb_desc_reader #(.EP0_MAXPKT(64), .HSSUPPORT(1)) u64 (
    .CLK(CLK), .RESET_N(RESET_N), .i_req_valid(req_valid), .i_desc_type(desc_type),
    .i_desc_index(desc_index), .i_wlength(wlength), .i_highspeed(highspeed),
    .i_desc_dev_addr(10'(A_DEV)), .i_desc_qual_addr(10'(A_QUAL)),
    .i_desc_fscfg_addr(10'(A_FS)), .i_desc_fscfg_len(8'(L_FS)),
    .i_desc_hscfg_addr(10'(A_HS)), .i_desc_hscfg_len(8'(L_HS)),
    .i_desc_strlang_addr(10'(A_LANG)), .i_desc_strvendor_addr(10'(A_VEN)),
    .i_desc_strvendor_len(8'(L_VEN)), .i_desc_strproduct_addr(10'(A_PRO)),
    .i_desc_strproduct_len(8'(L_PRO)), .i_desc_strserial_addr(10'(A_SER)),
    .i_desc_strserial_len(8'(L_SER)), .i_descrom_have_strings(have_strings),
    .o_descrom_raddr(raddr[0]), .i_descrom_rdat(rdat[0]), .i_in_token(in_token),
    .i_ack(ack), .i_nak_retry(nak), .o_txdat(txdat[0]), .o_txvalid(txvalid[0]),
    .i_txready(txready), .o_txlast(txlast[0]), .o_zlp(zlp[0]), .o_stall(stall[0]),
    .o_busy(busy[0])
  );

  usb_desc_reader #(.EP0_MAXPKT(16), .HSSUPPORT(0)) u16 (
    .CLK(CLK), .RESET_N(RESET_N), .i_req_valid(req_valid), .i_desc_type(desc_type),
    .i_desc_index(desc_index), .i_wlength(wlength), .i_highspeed(highspeed),
    .i_desc_dev_addr(10'(A_DEV)), .i_desc_qual_addr(10'(A_QUAL)),
    .i_desc_fscfg_addr(10'(A_FS)), .i_desc_fscfg_len(8'(L_FS)),
    .i_desc_hscfg_addr(10'(A_HS)), .i_desc_hscfg_len(8'(L_HS)),
    .i_desc_strlang_addr(10'(A_LANG)), .i_desc_strvendor_addr(10'(A_VEN)),
    .i_desc_strvendor_len(8'(L_VEN)), .i_desc_strproduct_addr(10'(A_PRO)),
    .i_desc_strproduct_len(8'(L_PRO)), .i_desc_strserial_addr(10'(A_SER)),
    .i_desc_strserial_len(8'(L_SER)), .i_descrom_have_strings(have_strings),
    .o_descrom_raddr(raddr[1]), .i_descrom_rdat(rdat[1]), .i_in_token(in_token),
    .i_ack(ack), .i_nak_retry(nak), .o_txdat(txdat[1]), .o_txvalid(txvalid[1]),
    .i_txready(txready), .o_txlast(txlast[1]), .o_zlp(zlp[1]), .o_stall(stall[1]),
    .o_busy(busy[1])
  );

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic int mpk(input int k);
    return (k == 0) ? 64 : 16;
  endfunction

  // Descriptor table as the host sees it: which ROM image and how long
  function automatic void desc_sel(input int k, input int t, input int idx, input bit hs,
                                   input bit hstr, output int b, output int ln,
                                   output bit sb, output bit st);
    b = 0; ln = 0; sb = 0; st = 0;
    case (t)
      1: begin b = A_DEV; ln = 18; end
      2: begin b = hs ? A_HS : A_FS; ln = hs ? L_HS : L_FS; end
      6: if (k == 0) begin b = A_QUAL; ln = 10; end else st = 1;
      7: if (k == 0) begin b = hs ? A_FS : A_HS; ln = hs ? L_FS : L_HS; sb = 1; end else st = 1;
      3: begin
        if (!hstr || idx > 3) st = 1;
        else if (idx == 0) begin b = A_LANG; ln = 4; end
        else if (idx == 1) begin b = A_VEN; ln = L_VEN; end
        else if (idx == 2) begin b = A_PRO; ln = L_PRO; end
        else begin b = A_SER; ln = L_SER; end
      end
      default: st = 1;
    endcase
  endfunction

  // Transfer-level model: phase 0 idle, 1 lookup, 2 waiting for IN, 3 packet out, 4 awaiting handshake
  int   ph[2], tot[2], snt[2], need[2], zpend[2], mbase[2], msub[2], mstall[2], mzlp[2];
  int   plen[2], pidx[2];
  logic [7:0] pb [2][64];
  int   pa [2][64];
  logic [7:0] l_type, l_idx;
  logic [15:0] l_wlen;
  logic l_hs;

  always @(posedge CLK) begin : model
    int b, ln;
    bit sb, st;
    for (int k = 0; k < 2; k++) begin
      mzlp[k] = 0;
      if (!RESET_N) begin
        ph[k] = 0; mstall[k] = 0; zpend[k] = 0;
      end else if (req_valid) begin
        ph[k] = 1; mstall[k] = 0; zpend[k] = 0;
      end else begin
        case (ph[k])
          1: begin
            desc_sel(k, int'(l_type), int'(l_idx), l_hs, have_strings, b, ln, sb, st);
            if (st) begin
              mstall[k] = 1; ph[k] = 0;
            end else begin
              tot[k] = (int'(l_wlen) < ln) ? int'(l_wlen) : ln;
              need[k] = ((tot[k] % mpk(k)) == 0) && (tot[k] < int'(l_wlen));
              zpend[k] = (tot[k] == 0);
              snt[k] = 0; mbase[k] = b; msub[k] = sb; ph[k] = 2;
            end
          end
          2: if (in_token) begin
            if (zpend[k]) begin
              mzlp[k] = 1; zpend[k] = 0; ph[k] = 0;
            end else begin
              plen[k] = (tot[k] - snt[k] > mpk(k)) ? mpk(k) : tot[k] - snt[k];
              for (int j = 0; j < plen[k]; j++) begin
                pa[k][j] = (mbase[k] + snt[k] + j) % 1024;
                pb[k][j] = (msub[k] && snt[k] + j == 1) ? 8'h07 : rom[pa[k][j]];
              end
              pidx[k] = 0; ph[k] = 3;
            end
          end
          3: if (txready) begin
            pidx[k]++;
            if (pidx[k] == plen[k]) ph[k] = 4;
          end
          4: begin
            if (nak) ph[k] = 2;
            else if (ack) begin
              snt[k] += plen[k];
              if (snt[k] < tot[k]) ph[k] = 2;
              else if (need[k]) begin zpend[k] = 1; ph[k] = 2; end
              else ph[k] = 0;
            end
          end
          default: ph[k] = 0;
        endcase
      end
    end
    if (RESET_N && req_valid) begin
      l_type = desc_type; l_idx = desc_index; l_wlen = wlength; l_hs = highspeed;
    end
  end

  // Per-cycle compare against the model, plus capture of accepted bytes
  bit cmp_on = 0;
  logic [7:0] cap [2][256];
  int capn[2], lastcnt[2], zcnt[2];

  always @(negedge CLK) begin
    if (cmp_on) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("busy%0d", k), int'(busy[k]), int'(ph[k] != 0));
        chk($sformatf("stall%0d", k), int'(stall[k]), mstall[k]);
        chk($sformatf("zlp%0d", k), int'(zlp[k]), mzlp[k]);
        chk($sformatf("txvalid%0d", k), int'(txvalid[k]), int'(ph[k] == 3));
        if (ph[k] == 3) begin
          chk($sformatf("txdat%0d", k), int'(txdat[k]), int'(pb[k][pidx[k]]));
          chk($sformatf("txlast%0d", k), int'(txlast[k]), int'(pidx[k] == plen[k] - 1));
          chk($sformatf("raddr%0d", k), int'(raddr[k]), pa[k][pidx[k]]);
        end
        if (txvalid[k] && txready && capn[k] < 256) begin
          cap[k][capn[k]] = txdat[k];
          capn[k]++;
          if (txlast[k]) lastcnt[k]++;
        end
        if (zlp[k]) zcnt[k]++;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_caps();
    for (int k = 0; k < 2; k++) begin capn[k] = 0; lastcnt[k] = 0; zcnt[k] = 0; end
  endtask

  task automatic send_req(input int t, input int idx, input int wl, input bit hs);
    desc_type = 8'(t); desc_index = 8'(idx); wlength = 16'(wl); highspeed = hs;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    do begin
      txready = ($urandom % 4) != 0;
      tick();
      n++;
    end while ((txvalid[0] || txvalid[1]) && n < 400);
    txready = 1'b0;
    if (n >= 400) chk("drain_timeout", n, 0);
  endtask

  task automatic rounds(input int nak_round);
    for (int r = 0; r < 8 && (busy[0] || busy[1]); r++) begin
      repeat ($urandom_range(0, 2)) tick();
      in_token = 1'b1; tick(); in_token = 1'b0;
      drain();
      repeat ($urandom_range(0, 2)) tick();
      if (r == nak_round) nak = 1'b1; else ack = 1'b1;
      tick();
      nak = 1'b0; ack = 1'b0;
    end
    chk("xfer_done", int'(busy[0] | busy[1]), 0);
  endtask

  task automatic run_xfer(input int t, input int idx, input int wl, input bit hs, input int nak_round);
    clear_caps();
    send_req(t, idx, wl, hs);
    tick();
    rounds(nak_round);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom);
    rom[A_DEV] = 8'h12;
    rom[A_DEV + 1] = 8'h01;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      chk("rst_raddr", int'(raddr[k]), 0);
      chk("rst_txvalid", int'(txvalid[k]), 0);
      chk("rst_txlast", int'(txlast[k]), 0);
      chk("rst_zlp", int'(zlp[k]), 0);
      chk("rst_stall", int'(stall[k]), 0);
      chk("rst_busy", int'(busy[k]), 0);
    end
    RESET_N = 1'b1;
    cmp_on = 1;
    tick();

    // Device descriptor, full length
    run_xfer(1, 0, 64, 0, -1);
    chk("dev_bytes64", capn[0], 18);
    chk("dev_last64", lastcnt[0], 1);
    chk("dev_zlp64", zcnt[0], 0);
    chk("dev_bytes16", capn[1], 18);
    chk("dev_last16", lastcnt[1], 2);

    // Truncated device descriptor
    run_xfer(1, 0, 8, 0, -1);
    chk("trunc_bytes", capn[0], 8);
    chk("trunc_b0", int'(cap[0][0]), 8'h12);
    chk("trunc_b1", int'(cap[0][1]), 8'h01);

    // HS configuration, two full packets plus ZLP on the 16-byte endpoint, retry of packet 2
    run_xfer(2, 0, 255, 1, 1);
    chk("cfg_bytes16", capn[1], 48);
    chk("cfg_zlp16", zcnt[1], 1);
    chk("cfg_bytes64", capn[0], 32);
    chk("cfg_zlp64", zcnt[0], 0);
    for (int j = 0; j < 16; j++) begin
      chk("pkt2_first", int'(cap[1][16 + j]), int'(rom[A_HS + 16 + j]));
      chk("pkt2_replay", int'(cap[1][32 + j]), int'(rom[A_HS + 16 + j]));
    end

    // Other-speed configuration at high speed: FS image with type byte patched
    run_xfer(7, 0, 255, 1, -1);
    chk("os_bytes", capn[0], L_FS);
    chk("os_b0", int'(cap[0][0]), int'(rom[A_FS]));
    chk("os_b1", int'(cap[0][1]), 8'h07);
    chk("os_b2", int'(cap[0][2]), int'(rom[A_FS + 2]));
    chk("os_stall_nohs", int'(stall[1]), 1);

    // String index 4 stalls two cycles after the request
    send_req(3, 4, 64, 0);
    chk("stall_at_lookup", int'(stall[0]), 0);
    tick();
    chk("stall_2cyc", int'(stall[0]), 1);
    chk("stall_idle", int'(busy[0]), 0);

    // Qualifier: stalls without HS support, then abort mid-send with a new request
    clear_caps();
    send_req(6, 0, 64, 1);
    tick();
    chk("qual_stall16", int'(stall[1]), 1);
    in_token = 1'b1; tick(); in_token = 1'b0;
    txready = 1'b1; tick(); tick();
    chk("qual_midsend", int'(txvalid[0]), 1);
    txready = 1'b0;
    clear_caps();
    send_req(1, 0, 64, 0);
    chk("abort_valid", int'(txvalid[0]), 0);
    chk("abort_busy", int'(busy[0]), 1);
    chk("abort_stall_clr", int'(stall[1]), 0);
    tick();
    rounds(-1);
    chk("abort_newxfer", capn[0], 18);

    // Randomized requests
    for (int n = 0; n < 40; n++) begin
      int t, idx, wl;
      case ($urandom % 7)
        0: t = 1; 1: t = 2; 2, 3: t = 3; 4: t = 6; 5: t = 7;
        default: t = $urandom_range(8, 255);
      endcase
      idx = $urandom_range(0, 4);
      case ($urandom % 4)
        0: wl = 0;
        1: wl = $urandom_range(1, 70);
        2: wl = 16 * $urandom_range(1, 4);
        default: wl = $urandom_range(1, 300);
      endcase
      have_strings = ($urandom % 4) != 0;
      repeat ($urandom_range(0, 3)) tick();
      run_xfer(t, idx, wl, 1'($urandom % 2), $urandom_range(0, 4) - 1);
    end

    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
